// File: rtl/fir_interp2.sv
// Interpolate-by-2 polyphase FIR, 8 taps, one shared multiplier and accumulator.
// Each accepted sample yields an even-phase then an odd-phase saturated 16-bit output.
module fir_interp2 #(
  parameter logic signed [7:0] H0 = -8'sd2,
  parameter logic signed [7:0] H1 = -8'sd1,
  parameter logic signed [7:0] H2 = 8'sd3,
  parameter logic signed [7:0] H3 = 8'sd4,
  parameter logic signed [7:0] H4 = 8'sd1,
  parameter logic signed [7:0] H5 = 8'sd1,
  parameter logic signed [7:0] H6 = 8'sd1,
  parameter logic signed [7:0] H7 = 8'sd1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic signed [7:0]  Xin,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] Yout,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MAC_EVEN = 3'd1,
    OUT_EVEN = 3'd2,
    MAC_ODD  = 3'd3,
    OUT_ODD  = 3'd4
  } state_t;

  state_t                state_r;
  logic signed [7:0]     x0_r, x1_r, x2_r, x3_r;
  logic signed [17:0]    acc_r;
  logic [1:0]            idx_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic signed [15:0]    yout_r;

  logic signed [7:0]     coef_s;
  logic signed [7:0]     samp_s;
  logic signed [15:0]    prod_s;
  logic signed [17:0]    sum_s;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      sat16 = 16'sh7FFF;
    end else if (v < -18'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  // Coefficient and tap selection for the current phase and tap index.
  always_comb begin
    coef_s = 8'sd0;
    samp_s = 8'sd0;
    case ({(state_r == MAC_ODD), idx_r})
      3'b000:  coef_s = H0;
      3'b001:  coef_s = H2;
      3'b010:  coef_s = H4;
      3'b011:  coef_s = H6;
      3'b100:  coef_s = H1;
      3'b101:  coef_s = H3;
      3'b110:  coef_s = H5;
      3'b111:  coef_s = H7;
      default: coef_s = 8'sd0;
    endcase
    case (idx_r)
      2'd0:    samp_s = x0_r;
      2'd1:    samp_s = x1_r;
      2'd2:    samp_s = x2_r;
      2'd3:    samp_s = x3_r;
      default: samp_s = 8'sd0;
    endcase
  end

  assign prod_s = coef_s * samp_s;
  assign sum_s  = acc_r + $signed({{2{prod_s[15]}}, prod_s});

  // Sequencer: sample intake, two 4-cycle MAC passes, and output handshakes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= IDLE;
      x0_r        <= 8'sd0;
      x1_r        <= 8'sd0;
      x2_r        <= 8'sd0;
      x3_r        <= 8'sd0;
      acc_r       <= 18'sd0;
      idx_r       <= 2'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      yout_r      <= 16'sd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            x3_r       <= x2_r;
            x2_r       <= x1_r;
            x1_r       <= x0_r;
            x0_r       <= Xin;
            acc_r      <= 18'sd0;
            idx_r      <= 2'd0;
            in_ready_r <= 1'b0;
            state_r    <= MAC_EVEN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        MAC_EVEN, MAC_ODD: begin
          if (idx_r == 2'd3) begin
            yout_r      <= sat16(sum_s);
            acc_r       <= 18'sd0;
            idx_r       <= 2'd0;
            out_valid_r <= 1'b1;
            state_r     <= (state_r == MAC_EVEN) ? OUT_EVEN : OUT_ODD;
          end else begin
            acc_r <= sum_s;
            idx_r <= idx_r + 2'd1;
          end
        end
        OUT_EVEN: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= MAC_ODD;
          end
        end
        OUT_ODD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          acc_r       <= 18'sd0;
          idx_r       <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Yout      = yout_r;

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: default-coefficient instance plus a saturating-override instance,
// both checked against an arithmetic convolution model and hand-computed literals.
module tb_fir_interp2;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  logic signed [7:0]  xin_a, xin_b;
  logic               inv_a, inv_b, inr_a, inr_b, ov_a, ov_b, ordy_a, ordy_b;
  logic signed [15:0] y_a, y_b;

  fir_interp2 dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Xin(xin_a), .in_valid(inv_a), .in_ready(inr_a),
    .Yout(y_a), .out_valid(ov_a), .out_ready(ordy_a)
  );

  fir_interp2 #(.H0(8'sd127), .H2(8'sd127), .H4(8'sd127), .H6(8'sd127)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Xin(xin_b), .in_valid(inv_b), .in_ready(inr_b),
    .Yout(y_b), .out_valid(ov_b), .out_ready(ordy_b)
  );

  int coef [2][8] = '{'{-2, -1, 3, 4, 1, 1, 1, 1}, '{127, -1, 127, 4, 127, 1, 127, 1}};
  int hist [2][4];
  int exp_a[$], exp_b[$], got_a[$], got_b[$];
  int tests = 0;
  int fails = 0;

  int imp    [10] = '{-2, -1, 3, 4, 1, 1, 1, 1, 0, 0};
  int const10[12] = '{-20, -10, 10, 30, 20, 40, 30, 50, 30, 50, 30, 50};

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) hist[w][k] = 0;
    exp_a.delete();
    exp_b.delete();
  endtask

  // y[2m] = sum h[2k] x[m-k], y[2m+1] = sum h[2k+1] x[m-k]
  task automatic model_accept(input int which, input int x);
    int s_e, s_o;
    for (int k = 3; k > 0; k--) hist[which][k] = hist[which][k-1];
    hist[which][0] = x;
    s_e = 0;
    s_o = 0;
    for (int k = 0; k < 4; k++) begin
      s_e += coef[which][2*k]   * hist[which][k];
      s_o += coef[which][2*k+1] * hist[which][k];
    end
    if (which == 0) begin
      exp_a.push_back(sat(s_e));
      exp_a.push_back(sat(s_o));
    end else begin
      exp_b.push_back(sat(s_e));
      exp_b.push_back(sat(s_o));
    end
  endtask

  task automatic send(input int which, input int x);
    int n = 0;
    if (which == 0) begin
      xin_a = 8'(x);
      inv_a = 1'b1;
    end else begin
      xin_b = 8'(x);
      inv_b = 1'b1;
    end
    while (((which == 0) ? inr_a : inr_b) == 1'b0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (((which == 0) ? inr_a : inr_b) == 1'b0) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      model_accept(which, x);
    end
    @(negedge Clk);
    inv_a = 1'b0;
    inv_b = 1'b0;
  endtask

  task automatic drain(input int which, input string name);
    int n = 0;
    while (((which == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 500) begin
      @(negedge Clk);
      n++;
    end
    check(name, (which == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  task automatic wait_valid_a(input string name);
    int n = 0;
    while (!ov_a && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check(name, int'(ov_a), 1);
  endtask

  // Output scoreboard: every accepted output is compared against the model queue.
  always begin
    @(negedge Clk);
    #1;
    if (Rst_n && ov_a && ordy_a) begin
      got_a.push_back(int'(y_a));
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_extra: got %0d, expected no output", y_a);
      end else begin
        check("a_stream", int'(y_a), exp_a.pop_front());
      end
    end
    if (Rst_n && ov_b && ordy_b) begin
      got_b.push_back(int'(y_b));
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_extra: got %0d, expected no output", y_b);
      end else begin
        check("b_stream", int'(y_b), exp_b.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int hold, lat;
    Rst_n  = 1'b0;
    xin_a  = 8'sd0;
    xin_b  = 8'sd0;
    inv_a  = 1'b0;
    inv_b  = 1'b0;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_in_ready_a", int'(inr_a), 0);
    check("rst_out_valid_a", int'(ov_a), 0);
    check("rst_yout_a", int'(y_a), 0);
    check("rst_in_ready_b", int'(inr_b), 0);
    check("rst_out_valid_b", int'(ov_b), 0);
    check("rst_yout_b", int'(y_b), 0);
    Rst_n = 1'b1;

    // Impulse response
    got_a.delete();
    send(0, 1);
    repeat (4) send(0, 0);
    drain(0, "impulse_drain");
    check("impulse_count", got_a.size(), 10);
    for (int i = 0; i < 10 && i < got_a.size(); i++) check("impulse_lit", got_a[i], imp[i]);

    // Constant input 10
    got_a.delete();
    repeat (6) send(0, 10);
    drain(0, "const_drain");
    check("const_count", got_a.size(), 12);
    for (int i = 0; i < 12 && i < got_a.size(); i++) check("const_lit", got_a[i], const10[i]);

    // Negative extreme
    got_a.delete();
    repeat (5) send(0, -128);
    drain(0, "neg_drain");
    check("neg_count", got_a.size(), 10);
    if (got_a.size() == 10) begin
      check("neg_even4", got_a[6], -384);
      check("neg_odd4", got_a[7], -640);
      check("neg_even5", got_a[8], -384);
      check("neg_odd5", got_a[9], -640);
    end

    // Backpressure in OUT_EVEN
    ordy_a = 1'b0;
    send(0, 5);
    wait_valid_a("bp_even_valid");
    hold = int'(y_a);
    check("bp_even_lit", hold, -650);
    repeat (7) begin
      @(negedge Clk);
      check("bp_hold_valid", int'(ov_a), 1);
      check("bp_hold_yout", int'(y_a), hold);
      check("bp_hold_in_ready", int'(inr_a), 0);
    end
    ordy_a = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!ov_a && lat < 20);
    check("bp_odd_latency", lat, 5);
    check("bp_odd_lit", int'(y_a), -773);
    drain(0, "bp_drain");

    // Saturation on the override instance
    got_b.delete();
    repeat (4) send(1, -128);
    repeat (4) send(1, 127);
    drain(1, "sat_drain");
    check("sat_count", got_b.size(), 16);
    if (got_b.size() == 16) begin
      check("sat_neg_even", got_b[6], -32768);
      check("sat_neg_odd", got_b[7], -640);
      check("sat_pos_even", got_b[14], 32767);
      check("sat_pos_odd", got_b[15], 635);
    end

    // Async reset in MAC_ODD with idx=2
    send(0, 7);
    wait_valid_a("rst_mid_even_valid");
    repeat (3) @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", int'(ov_a), 0);
    check("rst_mid_in_ready", int'(inr_a), 0);
    check("rst_mid_yout", int'(y_a), 0);
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    got_a.delete();
    send(0, 1);
    repeat (4) send(0, 0);
    drain(0, "post_rst_drain");
    check("post_rst_count", got_a.size(), 10);
    for (int i = 0; i < 10 && i < got_a.size(); i++) check("post_rst_lit", got_a[i], imp[i]);

    repeat (3) @(negedge Clk);
    check("final_exp_a_empty", exp_a.size(), 0);
    check("final_exp_b_empty", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
